// File: rtl/bitbang_slave_if.sv
`default_nettype none
// ============================================================================
// Module  : bitbang_slave_if
// Purpose : FPGA-side responder of the host bit-bang link. Deserialises a
//           64-byte work frame (32-byte midstate, then 32-byte data tail)
//           from rxc/rxd strobes, and returns queued golden nonces to the
//           host bit-by-bit on txc strobes (flag bit before every byte).
// Ports   : clk, rst_n (async, active low)
//           rxd, rxc, rxtxr, txc : host pads, asynchronous to clk
//           txd                  : registered serial data/flag to host
//           work_midstate/data   : last complete frame; work_valid pulses
//           nonce_in, nonce_wr   : nonce push from the hashing core
//           fifo_full            : nonce queue full
//           overflow_cnt         : saturating count of dropped nonces
// Config  : define BB_NONCE_PARITY_EN to append an odd-parity bit after
//           each transmitted byte (9 bits per byte instead of 8).
// Revision: 1.0 - initial release
// ============================================================================
module bitbang_slave_if #(
  parameter int SYNC_STAGES      = 2,
  parameter int NONCE_FIFO_DEPTH = 4,
  parameter int NONCE_FIFO_AW    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rxd,
  input  logic         rxc,
  input  logic         rxtxr,
  input  logic         txc,
  output logic         txd,
  output logic [255:0] work_midstate,
  output logic [255:0] work_data,
  output logic         work_valid,
  input  logic [31:0]  nonce_in,
  input  logic         nonce_wr,
  output logic         fifo_full,
  output logic [7:0]   overflow_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2
  } tx_state_t;

  // All four pads share one chain so rxd arrives aligned with its rxc edge.
  logic [3:0] sync_q [SYNC_STAGES];
  logic       rxd_s, rxc_s, rxtxr_s, txc_s;
  logic       rxc_prev, txc_prev;
  logic       rx_edge, tx_edge;

  assign {txc_s, rxtxr_s, rxc_s, rxd_s} = sync_q[SYNC_STAGES-1];
  // Strobe edges are suppressed while the host holds resync high.
  assign rx_edge = rxc_s & ~rxc_prev & ~rxtxr_s;
  assign tx_edge = txc_s & ~txc_prev & ~rxtxr_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      rxc_prev <= 1'b0;
      txc_prev <= 1'b0;
    end else begin
      sync_q[0] <= {txc, rxtxr, rxc, rxd};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      rxc_prev <= rxc_s;
      txc_prev <= txc_s;
    end
  end

  // ---------------------------------------------------------------- RX path
  logic [2:0]   bit_cnt;
  logic [5:0]   byte_cnt;
  logic [7:0]   byte_sr;
  logic [503:0] shadow;   // first 63 bytes; the 64th joins on the copy
  logic [7:0]   byte_next;

  assign byte_next = {rxd_s, byte_sr[7:1]};   // LSB arrives first

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt       <= '0;
      byte_cnt      <= '0;
      byte_sr       <= '0;
      shadow        <= '0;
      work_midstate <= '0;
      work_data     <= '0;
      work_valid    <= 1'b0;
    end else begin
      work_valid <= 1'b0;
      if (rxtxr_s) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (rx_edge) begin
        byte_sr <= byte_next;
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          shadow   <= {shadow[495:0], byte_next};
          byte_cnt <= byte_cnt + 6'd1;
          if (byte_cnt == 6'd63) begin
            {work_midstate, work_data} <= {shadow, byte_next};
            work_valid                 <= 1'b1;
          end
        end
      end
    end
  end

  // ------------------------------------------------------------ nonce queue
  logic [31:0]              mem [NONCE_FIFO_DEPTH];
  logic [NONCE_FIFO_AW:0]   wr_ptr, rd_ptr;
  logic                     empty, full, push, pop;
  logic [31:0]              head;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[NONCE_FIFO_AW] != rd_ptr[NONCE_FIFO_AW]) &&
                     (wr_ptr[NONCE_FIFO_AW-1:0] == rd_ptr[NONCE_FIFO_AW-1:0]);
  assign fifo_full = full;
  assign head      = mem[rd_ptr[NONCE_FIFO_AW-1:0]];
  // A pop in the same cycle frees the slot, so a write to a full queue is kept.
  assign push      = nonce_wr & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[NONCE_FIFO_AW-1:0]] <= nonce_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (nonce_wr && full && !pop && overflow_cnt != 8'hFF)
        overflow_cnt <= overflow_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------- TX path
  tx_state_t  tx_state;
  logic [2:0] bit_idx;
  logic [1:0] byte_idx;
  logic [7:0] tx_byte;

  always_comb begin
    tx_byte = head[31:24];
    case (byte_idx)
      2'd0:    tx_byte = head[31:24];
      2'd1:    tx_byte = head[23:16];
      2'd2:    tx_byte = head[15:8];
      default: tx_byte = head[7:0];
    endcase
  end

  // Head leaves the queue on the edge that completes its last byte.
  always_comb begin
`ifdef BB_NONCE_PARITY_EN
    pop = tx_edge && !empty && (tx_state == S_PAR) && (byte_idx == 2'd3);
`else
    pop = tx_edge && !empty && (tx_state == S_DATA) && (bit_idx == 3'd7) &&
          (byte_idx == 2'd3);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      bit_idx  <= '0;
      byte_idx <= '0;
      txd      <= 1'b0;
    end else if (rxtxr_s) begin
      // Resync restarts the current head nonce from its first byte.
      tx_state <= S_IDLE;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else if (tx_edge) begin
      case (tx_state)
        S_IDLE: begin
          if (!empty) begin
            txd      <= 1'b1;
            bit_idx  <= '0;
            tx_state <= S_DATA;
          end else begin
            txd <= 1'b0;
          end
        end
        S_DATA: begin
          txd     <= tx_byte[bit_idx];
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef BB_NONCE_PARITY_EN
            tx_state <= S_PAR;
`else
            tx_state <= S_IDLE;
            byte_idx <= byte_idx + 2'd1;
`endif
          end
        end
`ifdef BB_NONCE_PARITY_EN
        S_PAR: begin
          txd      <= ~^tx_byte;
          tx_state <= S_IDLE;
          byte_idx <= byte_idx + 2'd1;
        end
`endif
        default: tx_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bitbang_slave_if.sv
`default_nettype none
// ============================================================================
// Module  : tb_bitbang_slave_if
// Purpose : Self-checking bench for bitbang_slave_if. A frame/bitstream
//           level model predicts every output; a compare process checks
//           them each settled cycle, and literal expectations pin the model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bitbang_slave_if;

  localparam int SYNC = 2;
`ifdef BB_NONCE_PARITY_EN
  localparam int BPB = 9;
`else
  localparam int BPB = 8;
`endif
  localparam int PER = 4 * (1 + BPB);   // host polls per nonce

  localparam logic [255:0] MID1  = 256'h228ea4732a3c9ba860c009cda7252b9161a5e75ec8c582a5f106abb3af41f790;
  localparam logic [255:0] DATA1 = 256'h000000000000000000000000_80000000_00000000_2194261a9395e64dbed17115;
  localparam logic [255:0] MID2  = 256'h0123456789abcdeffedcba98765432100f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [255:0] DATA2 = 256'hdeadbeefcafebabe0011223344556677_8899aabbccddeeff_a5a5a5a55a5a5a5a;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rxd = 1'b0, rxc = 1'b0, rxtxr = 1'b0, txc = 1'b0;
  logic         txd;
  logic [255:0] work_midstate, work_data;
  logic         work_valid;
  logic [31:0]  nonce_in = '0;
  logic         nonce_wr = 1'b0;
  logic         fifo_full;
  logic [7:0]   overflow_cnt;

  bitbang_slave_if #(.SYNC_STAGES(SYNC), .NONCE_FIFO_DEPTH(4), .NONCE_FIFO_AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .rxc(rxc), .rxtxr(rxtxr), .txc(txc),
    .txd(txd), .work_midstate(work_midstate), .work_data(work_data),
    .work_valid(work_valid), .nonce_in(nonce_in), .nonce_wr(nonce_wr),
    .fifo_full(fifo_full), .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // ------------------------------------------------------------------ model
  logic [31:0]  m_q[$];
  int           m_pos = 0;
  bit           m_bits[$];
  logic [255:0] exp_mid = '0, exp_data = '0;
  logic         exp_txd = 1'b0;
  int           exp_ovf = 0;
  int           exp_vcnt = 0;
  int           vcnt = 0;

  function automatic logic seq_bit(input logic [31:0] n, input int pos);
    int bi, r;
    logic [7:0] b;
    bi = pos / (1 + BPB);
    r  = pos % (1 + BPB);
    b  = 8'(n >> (8 * (3 - bi)));
    if (r == 0) return 1'b1;
    if (r <= 8) return b[r-1];
    return ~^b;
  endfunction

  task automatic model_poll();
    if (m_q.size() == 0) begin
      exp_txd = 1'b0;
    end else begin
      exp_txd = seq_bit(m_q[0], m_pos);
      m_pos++;
      if (m_pos == PER) begin
        void'(m_q.pop_front());
        m_pos = 0;
      end
    end
  endtask

  task automatic model_push(input logic [31:0] n);
    if (m_q.size() == 4) begin
      if (exp_ovf < 255) exp_ovf++;
    end else begin
      m_q.push_back(n);
    end
  endtask

  task automatic model_rxbit(input bit b);
    logic [511:0] fr;
    logic [7:0]   byt;
    m_bits.push_back(b);
    if (m_bits.size() == 512) begin
      fr = '0;
      for (int n = 0; n < 64; n++) begin
        for (int i = 0; i < 8; i++) byt[i] = m_bits[8*n + i];
        fr[511 - 8*n -: 8] = byt;
      end
      exp_mid  = fr[511:256];
      exp_data = fr[255:0];
      exp_vcnt++;
      m_bits.delete();
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_bits.delete();
    m_pos    = 0;
    exp_mid  = '0;
    exp_data = '0;
    exp_txd  = 1'b0;
    exp_ovf  = 0;
  endtask

  // ---------------------------------------------------------------- checker
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) if (rst_n && work_valid) vcnt++;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("txd", 256'(txd), 256'(exp_txd));
      chk("work_valid_idle", 256'(work_valid), 256'(0));
      chk("valid_count", 256'(vcnt), 256'(exp_vcnt));
      chk("work_midstate", work_midstate, exp_mid);
      chk("work_data", work_data, exp_data);
      chk("fifo_full", 256'(fifo_full), 256'(m_q.size() == 4));
      chk("overflow_cnt", 256'(overflow_cnt), 256'(exp_ovf));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  // ------------------------------------------------------------- host tasks
  task automatic rx_bit(input bit b);
    @(posedge clk); #1;
    chk_en = 1'b0; rxd = b; rxc = 1'b1;
    repeat (SYNC + 3) @(posedge clk); #1;
    model_rxbit(b); chk_en = 1'b1;
    @(posedge clk); #1;
    rxc = 1'b0;
    repeat (SYNC + 2) @(posedge clk);
  endtask

  task automatic send_frame(input logic [255:0] mid, input logic [255:0] dat);
    logic [511:0] fr;
    logic [7:0]   byt;
    fr = {mid, dat};
    for (int n = 0; n < 64; n++) begin
      byt = fr[511 - 8*n -: 8];
      for (int i = 0; i < 8; i++) rx_bit(byt[i]);
    end
  endtask

  task automatic tx_poll(output logic b);
    @(posedge clk); #1;
    chk_en = 1'b0; txc = 1'b1;
    model_poll();
    repeat (SYNC + 3) @(posedge clk); #1;
    chk_en = 1'b1; b = txd;
    @(posedge clk); #1;
    txc = 1'b0;
    repeat (SYNC + 2) @(posedge clk);
  endtask

  task automatic read_byte(output logic flag, output logic [7:0] b, output logic par);
    logic t;
    tx_poll(flag);
    for (int i = 0; i < 8; i++) begin
      tx_poll(t);
      b[i] = t;
    end
    par = 1'b0;
`ifdef BB_NONCE_PARITY_EN
    tx_poll(par);
`endif
  endtask

  task automatic read_nonce(input string nm, input logic [31:0] exp);
    logic       f, p;
    logic [7:0] b;
    logic [31:0] n;
    n = '0;
    for (int k = 0; k < 4; k++) begin
      read_byte(f, b, p);
      chk({nm, "_flag"}, 256'(f), 256'(1));
      n = {n[23:0], b};
    end
    chk(nm, 256'(n), 256'(exp));
  endtask

  task automatic push_burst(input logic [31:0] v[$]);
    @(posedge clk); #1;
    chk_en = 1'b0;
    foreach (v[k]) begin
      nonce_in = v[k]; nonce_wr = 1'b1;
      model_push(v[k]);
      @(posedge clk); #1;
    end
    nonce_wr = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic resync();
    @(posedge clk); #1;
    chk_en = 1'b0; rxtxr = 1'b1;
    repeat (SYNC + 3) @(posedge clk); #1;
    m_bits.delete(); m_pos = 0;
    rxtxr = 1'b0;
    repeat (SYNC + 3) @(posedge clk); #1;
    chk_en = 1'b1;
  endtask

  task automatic check_reset_values(input string nm);
    chk({nm, "_txd"}, 256'(txd), 256'(0));
    chk({nm, "_valid"}, 256'(work_valid), 256'(0));
    chk({nm, "_mid"}, work_midstate, 256'(0));
    chk({nm, "_data"}, work_data, 256'(0));
    chk({nm, "_full"}, 256'(fifo_full), 256'(0));
    chk({nm, "_ovf"}, 256'(overflow_cnt), 256'(0));
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    logic        f, p, t;
    logic [7:0]  b;
    logic [31:0] v[$];

    // Power-on reset
    repeat (3) @(posedge clk); #1;
    check_reset_values("por");
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (4) @(posedge clk);

    // Full work frame
    send_frame(MID1, DATA1);
    chk("frame1_mid", work_midstate, MID1);
    chk("frame1_data", work_data, DATA1);
    chk("frame1_pulses", 256'(vcnt), 256'(1));
    chk("model_mid_pin", exp_mid, MID1);

    // Single nonce readback, then empty polls
    v = '{32'h0e33337a};
    push_burst(v);
    read_byte(f, b, p); chk("n0_flag", 256'(f), 256'(1)); chk("n0_b0", 256'(b), 256'(8'h0e));
    read_byte(f, b, p); chk("n0_b1", 256'(b), 256'(8'h33));
    read_byte(f, b, p); chk("n0_b2", 256'(b), 256'(8'h33));
    read_byte(f, b, p); chk("n0_b3", 256'(b), 256'(8'h7a));
    tx_poll(t); chk("empty_poll0", 256'(t), 256'(0));
    tx_poll(t); chk("empty_poll1", 256'(t), 256'(0));

    // Partial frame discarded by resync
    for (int i = 0; i < 100; i++) rx_bit(1'((i % 3) == 0));
    resync();
    send_frame(MID2, DATA2);
    chk("frame2_mid", work_midstate, MID2);
    chk("frame2_data", work_data, DATA2);
    chk("frame2_pulses", 256'(vcnt), 256'(2));

    // Resync mid-nonce restarts the head from byte 0
    v = '{32'ha5c31234};
    push_burst(v);
    read_byte(f, b, p); chk("rs_b0", 256'(b), 256'(8'ha5));
    repeat (3) tx_poll(t);
    resync();
    read_nonce("rs_nonce", 32'ha5c31234);
    tx_poll(t); chk("rs_empty", 256'(t), 256'(0));

    // Overflow: five pushes into a four-entry queue
    v = '{32'h01020304, 32'ha0b0c0d0, 32'h55aa33cc, 32'hffff0000, 32'h12345678};
    push_burst(v);
    chk("ovf_full", 256'(fifo_full), 256'(1));
    chk("ovf_cnt1", 256'(overflow_cnt), 256'(1));
    read_nonce("q0", 32'h01020304);
    read_nonce("q1", 32'ha0b0c0d0);
    read_nonce("q2", 32'h55aa33cc);
    read_nonce("q3", 32'hffff0000);
    tx_poll(t); chk("q_empty", 256'(t), 256'(0));

    // Saturation of the drop counter
    v.delete();
    for (int i = 0; i < 264; i++) v.push_back(32'(i));
    push_burst(v);
    chk("ovf_sat", 256'(overflow_cnt), 256'(255));

    // Reset mid-frame with a full queue
    for (int i = 0; i < 37; i++) rx_bit(1'(i & 1));
    @(posedge clk); #1;
    chk_en = 1'b0; rst_n = 1'b0;
    model_reset();
    #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk); #1;
    check_reset_values("midrst");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    send_frame(DATA1, MID1);
    chk("frame3_mid", work_midstate, DATA1);
    chk("frame3_data", work_data, MID1);
    chk("frame3_pulses", 256'(vcnt), 256'(3));
    tx_poll(t); chk("rst_empty", 256'(t), 256'(0));

`ifdef BB_NONCE_PARITY_EN
    // Odd parity after each byte
    v = '{32'h00000001};
    push_burst(v);
    read_byte(f, b, p); chk("par_b0", 256'(b), 256'(8'h00)); chk("par_p0", 256'(p), 256'(1));
    read_byte(f, b, p); chk("par_b1", 256'(b), 256'(8'h00)); chk("par_p1", 256'(p), 256'(1));
    read_byte(f, b, p); chk("par_b2", 256'(b), 256'(8'h00)); chk("par_p2", 256'(p), 256'(1));
    read_byte(f, b, p); chk("par_b3", 256'(b), 256'(8'h01)); chk("par_p3", 256'(p), 256'(0));
`endif

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
